// File: rtl/spw_ulight_nofifo_status_in.sv
// Avalon-MM status input port: synchronised SpaceWire link status bits with
// per-bit sticky edge capture (W1C) and a masked, registered level interrupt.
module spw_ulight_nofifo_status_in #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EDGE_TYPE = 0,
  parameter int unsigned SYNC_EN   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] din_d, din_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_d, mask_q;
  logic [WIDTH-1:0] ec_d, ec_q;
  logic [WIDTH-1:0] rise, fall, edge_hit;
  logic [31:0]      rdata_d, rdata_q;
  logic             irq_d, irq_q;
  logic             wr_en;

  // With SYNC_EN the final synchroniser stage doubles as din; otherwise din is
  // a single register on in_port.
  if (SYNC_EN != 0) begin : g_sync
    logic [WIDTH-1:0] s1_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) s1_q <= '0;
      else          s1_q <= in_port;
    end
    assign din_d = s1_q;
  end else begin : g_nosync
    assign din_d = in_port;
  end

  always_comb begin
    rise     = din_q & ~prev_q;
    fall     = ~din_q & prev_q;
    edge_hit = rise;
    if (EDGE_TYPE == 1)      edge_hit = fall;
    else if (EDGE_TYPE == 2) edge_hit = rise | fall;
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    mask_d = mask_q;
    ec_d   = ec_q;
    if (wr_en && address == 2'd2) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) ec_d = ec_q & ~writedata[WIDTH-1:0];
    // Edge set is applied after the clear so a coincident edge wins.
    ec_d = ec_d | edge_hit;
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      2'd0:    rdata_d = 32'(din_q);
      2'd2:    rdata_d = 32'(mask_q);
      2'd3:    rdata_d = 32'(ec_q);
      default: rdata_d = '0;
    endcase
    irq_d = |(ec_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_q   <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      ec_q    <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      din_q   <= din_d;
      prev_q  <= din_q;
      mask_q  <= mask_d;
      ec_q    <= ec_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_spw_ulight_nofifo_status_in.sv
// Bench for spw_ulight_nofifo_status_in: three instances (rising/sync,
// falling/sync, any-edge/unsynchronised) share one Avalon bus.
module tb_spw_ulight_nofifo_status_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a, in_b, in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  spw_ulight_nofifo_status_in #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_EN(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a));

  spw_ulight_nofifo_status_in #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_EN(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b));

  spw_ulight_nofifo_status_in #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_EN(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_c),
    .readdata(rd_c), .irq(irq_c));

  task automatic push(input string n, input logic [1:0] ad,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    exp_t x;
    x.name = n; x.addr = ad; x.a = a; x.b = b; x.c = c;
    sbq.push_back(x);
  endtask

  // Present address at negedge; readdata is valid #1 after the next posedge.
  task automatic do_read(input logic [1:0] ad);
    @(negedge clk);
    address = ad; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Single-cycle write strobe; returns #1 after the capturing posedge.
  task automatic do_write(input logic [1:0] ad, input logic [31:0] d);
    @(negedge clk);
    address = ad; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); #1;
    write_n = 1'b1; chipselect = 1'b0; writedata = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rd_a, rd_b, rd_c, irq_a, irq_b, irq_c} !== '0) begin
      bad++;
      $display("FAIL reset_hold got rd a=%h b=%h c=%h irq=%b%b%b exp all 0",
               rd_a, rd_b, rd_c, irq_a, irq_b, irq_c);
    end
    @(negedge clk);
    reset_n = 1'b1;
    push("reset_data", 2'd0, 32'h0, 32'h0, 32'h0);
    push("reset_ec",   2'd3, 32'h0, 32'h0, 32'h0);
    push("reset_mask", 2'd2, 32'h0, 32'h0, 32'h0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b000) begin
      bad++;
      $display("FAIL reset_irq got=%b%b%b exp=000", irq_a, irq_b, irq_c);
    end
  endtask

  task automatic test_rise_latency();
    @(negedge clk);
    in_a = 4'h5; in_b = 4'h5; in_c = 4'h5;
    address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    // sync instances show DATA on the 3rd clk, the unsynchronised one on the 2nd
    push("lat_clk1", 2'd0, 32'h0, 32'h0, 32'h0);
    push("lat_clk2", 2'd0, 32'h0, 32'h0, 32'h5);
    push("lat_clk3", 2'd0, 32'h5, 32'h5, 32'h5);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      @(posedge clk); #1;
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    push("rise_ec",   2'd3, 32'h5, 32'h0, 32'h5);
    push("rise_data", 2'd0, 32'h5, 32'h5, 32'h5);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b000) begin
      bad++;
      $display("FAIL rise_irq_masked got=%b%b%b exp=000", irq_a, irq_b, irq_c);
    end
  endtask

  task automatic test_irq_mask();
    do_write(2'd2, 32'h1);
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b000) begin
      bad++;
      $display("FAIL irq_lag got=%b%b%b exp=000", irq_a, irq_b, irq_c);
    end
    @(posedge clk); #1;
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b101) begin
      bad++;
      $display("FAIL irq_set got=%b%b%b exp=101", irq_a, irq_b, irq_c);
    end
    do_write(2'd3, 32'h1);
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b101) begin
      bad++;
      $display("FAIL irq_hold got=%b%b%b exp=101", irq_a, irq_b, irq_c);
    end
    @(posedge clk); #1;
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b000) begin
      bad++;
      $display("FAIL irq_clear got=%b%b%b exp=000", irq_a, irq_b, irq_c);
    end
    push("w1c_ec",  2'd3, 32'h4, 32'h0, 32'h4);
    push("mask_rb", 2'd2, 32'h1, 32'h1, 32'h1);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    in_a = 4'h7; in_b = 4'h7; in_c = 4'h7;
    @(negedge clk);
    // A's edge on bit 1 lands on the same clk as this W1C; C's landed one earlier
    do_write(2'd3, 32'h2);
    push("setwins_ec", 2'd3, 32'h6, 32'h0, 32'h4);
    push("setwins_dat", 2'd0, 32'h7, 32'h7, 32'h7);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic test_falling();
    do_write(2'd3, 32'hFFFF_FFFF);
    push("fall_cleared", 2'd3, 32'h0, 32'h0, 32'h0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    @(negedge clk);
    in_b = 4'hF; in_c = 4'hF;
    repeat (4) @(negedge clk);
    push("fall_rise_only", 2'd3, 32'h0, 32'h0, 32'h8);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    @(negedge clk);
    in_b = 4'h0; in_c = 4'h0;
    repeat (4) @(negedge clk);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_write(2'd2, 32'hFFFF_FFFF);
    push("fall_ec",    2'd3, 32'h0, 32'hF, 32'hF);
    push("reserved",   2'd1, 32'h0, 32'h0, 32'h0);
    push("mask_trunc", 2'd2, 32'hF, 32'hF, 32'hF);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b011) begin
      bad++;
      $display("FAIL fall_irq got=%b%b%b exp=011", irq_a, irq_b, irq_c);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({rd_a, rd_b, rd_c, irq_a, irq_b, irq_c} !== '0) begin
      bad++;
      $display("FAIL midreset_async got rd a=%h b=%h c=%h irq=%b%b%b exp all 0",
               rd_a, rd_b, rd_c, irq_a, irq_b, irq_c);
    end
    @(negedge clk);
    reset_n = 1'b1;
    push("midreset_ec",   2'd3, 32'h0, 32'h0, 32'h0);
    push("midreset_mask", 2'd2, 32'h0, 32'h0, 32'h0);
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      do_read(e.addr);
      total++;
      if ({rd_a, rd_b, rd_c} !== {e.a, e.b, e.c}) begin
        bad++;
        $display("FAIL %s got a=%h b=%h c=%h exp a=%h b=%h c=%h",
                 e.name, rd_a, rd_b, rd_c, e.a, e.b, e.c);
      end
    end
    total++;
    if ({irq_a, irq_b, irq_c} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_irq got=%b%b%b exp=000", irq_a, irq_b, irq_c);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a = '0; in_b = '0; in_c = '0;
    test_reset();
    test_rise_latency();
    test_irq_mask();
    test_set_wins();
    test_falling();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
